// File: rtl/fft_output_ctrl.sv
// FFT output buffer sequencer: fills the sample buffer from the FFT stream,
// then drains it as wide lines toward the host/DMA stream.
module fft_output_ctrl #(
    parameter int SIZE        = 16,
    parameter int SAMPLES     = 2048,
    parameter int LINE_WIDTH  = 512,
    parameter int BIT_REVERSE = 0,
    localparam int LINES      = SAMPLES * SIZE / LINE_WIDTH,
    localparam int AW         = $clog2(SAMPLES),
    localparam int LW         = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [SIZE-1:0]       s_data,
    output logic                  s_ready,
    output logic                  buf_wr_en,
    output logic [AW-1:0]         buf_wr_index,
    output logic [SIZE-1:0]       buf_wr_data,
    output logic [LW-1:0]         buf_rd_index,
    input  logic [LINE_WIDTH-1:0] buf_rd_data,
    output logic                  m_valid,
    output logic [LINE_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] scnt, scnt_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic          done_n;
    logic [AW-1:0] scnt_rev;
    logic          in_fill, in_drain;

    assign in_fill  = (state == FILL);
    assign in_drain = (state == DRAIN);

    always_comb begin
        scnt_rev = '0;
        for (int i = 0; i < AW; i++) begin
            scnt_rev[i] = scnt[AW-1-i];
        end
    end

    assign s_ready      = in_fill;
    assign buf_wr_en    = in_fill && s_valid && !abort;
    assign buf_wr_index = (BIT_REVERSE != 0) ? scnt_rev : scnt;
    assign buf_wr_data  = in_fill ? s_data : '0;
    assign buf_rd_index = lcnt;
    assign m_valid      = in_drain;
    assign m_data       = in_drain ? buf_rd_data : '0;
    assign m_last       = in_drain && (lcnt == LW'(LINES - 1));
    assign busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        lcnt_n  = lcnt;
        done_n  = 1'b0;
        // abort outranks every other transition, including frame completion
        if (abort) begin
            state_n = IDLE;
            scnt_n  = '0;
            lcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FILL;
                        scnt_n  = '0;
                        lcnt_n  = '0;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        scnt_n = scnt + 1'b1;
                        if (scnt == AW'(SAMPLES - 1)) begin
                            state_n = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        lcnt_n = lcnt + 1'b1;
                        if (m_last) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            scnt       <= '0;
            lcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            scnt       <= scnt_n;
            lcnt       <= lcnt_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: doc/fft_output_ctrl.md
# fft_output_ctrl

Sequencing controller for the FFT output sample buffer. It accepts one frame of SAMPLES real-valued results from the FFT core over a valid/ready stream and writes them one per cycle into the buffer's sample-indexed write port. Once the frame is complete, it drains the buffer as LINES wide lines through the line-indexed read port onto a valid/ready output stream toward the host/DMA interface. It owns all buffer addressing; fill and drain never overlap.

## Interface
Parameters:
- SIZE, 16, bits per sample
- SAMPLES, 2048, samples per frame (power of two)
- LINE_WIDTH, 512, bits per output line; must be a multiple of SIZE
- BIT_REVERSE, 0, if 1 the write address is the bit-reversed sample counter (natural-order output from a bit-reversed FFT core)
- Derived: LINES = SAMPLES*SIZE/LINE_WIDTH (64); AW = $clog2(SAMPLES); LW = $clog2(LINES)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; honoured only in IDLE
- abort  in  1  synchronous abandon; returns to IDLE from any state
- s_valid  in  1  FFT sample valid
- s_data  in  SIZE  FFT sample
- s_ready  out  1  controller accepts sample
- buf_wr_en  out  1  buffer write enable
- buf_wr_index  out  AW  buffer write sample index
- buf_wr_data  out  SIZE  buffer write data
- buf_rd_index  out  LW  buffer read line index
- buf_rd_data  in  LINE_WIDTH  buffer line (combinational function of buf_rd_index)
- m_valid  out  1  output line valid
- m_data  out  LINE_WIDTH  output line
- m_last  out  1  current line is line LINES-1
- m_ready  in  1  downstream accepts line
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last line is accepted

## Operation
- States: IDLE, FILL, DRAIN. Registers: state, sample counter scnt (AW bits), line counter lcnt (LW bits), frame_done.
- IDLE: s_ready=0, m_valid=0. On start && !abort, go to FILL and clear scnt and lcnt to 0.
- FILL: s_ready=1. buf_wr_en = s_valid && s_ready; buf_wr_data = s_data; buf_wr_index = scnt, or bitrev(scnt) over AW bits when BIT_REVERSE=1. Each accepted sample increments scnt. When the sample at scnt==SAMPLES-1 is accepted, go to DRAIN; scnt wraps to 0.
- DRAIN: m_valid=1; buf_rd_index = lcnt; m_data = buf_rd_data (pass-through); m_last = (lcnt==LINES-1). Each m_valid && m_ready handshake increments lcnt. A handshake with m_last set goes to IDLE and sets frame_done for one cycle.
- Outside FILL: buf_wr_en=0, s_ready=0. Outside DRAIN: m_valid=0, m_last=0, buf_rd_index=lcnt.
- m_data and m_valid hold stable while m_valid && !m_ready.
- abort has priority over every other transition: next state IDLE, counters cleared, no frame_done, no buffer write in the abort cycle (buf_wr_en gated by !abort).
- start in FILL or DRAIN is ignored. start and abort together in IDLE stays IDLE.
- The buffer itself is not cleared by the controller; stale contents are overwritten by the next fill.

## Timing
- Reset values: state=IDLE, scnt=0, lcnt=0. All outputs 0, including s_ready, buf_wr_en, m_valid, busy and frame_done.
- start sampled at edge t gives FILL, busy=1 and s_ready=1 from cycle t+1.
- Write port is combinational from the stream. Sample k is stored at the edge where its handshake occurs.
- The last sample is accepted at edge e. DRAIN and m_valid=1 start in cycle e+1, and that sample is already visible in line LINES-1.
- Zero read latency: line j appears on m_data in the same cycle that lcnt==j.
- Minimum frame time with no stalls: 1 + SAMPLES + LINES cycles (2113 with defaults).
- frame_done is high in the cycle after the final handshake, coincident with busy=0. A start in that cycle is honoured.

## Test plan
- Reset mid-DRAIN (rst_n low at lcnt=10) -> all outputs 0 immediately; after release, state IDLE and a new start re-fills from index 0.
- Natural order, BIT_REVERSE=0: start, then 2048 samples with value k at sample k, s_valid always 1, m_ready always 1 -> writes land at index k. Line j carries samples 32j..32j+31, with sample 32j+i in bits [16i+15:16i]. m_last only on line 63. frame_done at cycle 2113.
- BIT_REVERSE=1 with samples k -> buf_wr_index = bitrev11(k), e.g. sample 1 goes to 1024 and sample 3 to 1536.
- Backpressure: random s_valid gaps and m_ready low for 5 cycles on line 7 -> m_data stable throughout the stall. No sample lost or duplicated; exactly 64 handshakes per frame.
- abort at scnt=100, with start asserted during FILL and during DRAIN -> the abort cycle has no write, and the controller reaches IDLE with no frame_done. The start pulses during FILL and DRAIN are ignored.
- Back-to-back frames: start in the frame_done cycle -> the second frame begins FILL on the next cycle and its data is correct.
